clk_ce_nco: RTL



---
 rtl/clk_ce_pkg.sv | 11 +
 rtl/nco_chan.sv | 78 +++++++
 rtl/clk_ce_nco.sv | 65 ++++++
 3 files changed

// File: rtl/clk_ce_pkg.sv
// Shared definitions for the fractional clock-enable NCO.
package clk_ce_pkg;

   localparam int DEFAULT_LOCK_CYCLES = 16;

   // Width needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nco_chan.sv
// One phase-accumulator channel with a shadowed increment that is only
// swapped in at a period boundary, so rate changes never shorten a period.
module nco_chan
   import clk_ce_pkg::*;
#(
   parameter int               ACC_W    = 32,
   parameter logic [ACC_W-1:0] INIT_INC = '0
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             en,
   input  logic             we,
   input  logic [ACC_W-1:0] wdata,
   input  logic             resync,
   output logic             ce,
   output logic             pending,
   output logic             applied
);

   logic [ACC_W-1:0] acc, inc, shadow;
   logic [ACC_W-1:0] acc_nxt, inc_nxt, shadow_nxt;
   logic             pending_nxt, ce_nxt, carry;
   logic [ACC_W:0]   sum;

   always_comb begin
      sum         = {1'b0, acc} + {1'b0, inc};
      carry       = en & sum[ACC_W];
      acc_nxt     = acc;
      inc_nxt     = inc;
      shadow_nxt  = we ? wdata : shadow;
      pending_nxt = pending;
      ce_nxt      = 1'b0;
      applied     = 1'b0;
      if (resync) begin
         acc_nxt     = '0;
         pending_nxt = 1'b0;
         if (we) begin
            inc_nxt = wdata;
            applied = 1'b1;
         end else if (pending) begin
            inc_nxt = shadow;
            applied = 1'b1;
         end
      end else begin
         if (en) acc_nxt = sum[ACC_W-1:0];
         ce_nxt = carry;
         // A stopped channel has no period to protect, so it takes writes at once.
         if (we && (carry || !en)) begin
            inc_nxt     = wdata;
            pending_nxt = 1'b0;
            applied     = 1'b1;
         end else if (we) begin
            pending_nxt = 1'b1;
         end else if (pending && (carry || !en)) begin
            inc_nxt     = shadow;
            pending_nxt = 1'b0;
            applied     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         acc     <= '0;
         inc     <= INIT_INC;
         shadow  <= INIT_INC;
         pending <= 1'b0;
         ce      <= 1'b0;
      end else begin
         acc     <= acc_nxt;
         inc     <= inc_nxt;
         shadow  <= shadow_nxt;
         pending <= pending_nxt;
         ce      <= ce_nxt;
      end
   end

endmodule

// File: rtl/clk_ce_nco.sv
// Multi-channel fractional clock-enable generator with write decode and a
// PLL-style locked indication that drops whenever any rate changes.
module clk_ce_nco
   import clk_ce_pkg::*;
#(
   parameter int                      NUM_CH      = 3,
   parameter int                      ACC_W       = 32,
   parameter int                      LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
   parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = '0
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic [NUM_CH-1:0]             ch_en,
   input  logic                          cfg_we,
   input  logic [clog2_min1(NUM_CH)-1:0] cfg_ch,
   input  logic [ACC_W-1:0]              cfg_data,
   input  logic                          resync,
   output logic [NUM_CH-1:0]             ce,
   output logic [NUM_CH-1:0]             cfg_pending,
   output logic                          locked
);

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int CNT_W = clog2_min1(LOCK_CYCLES + 1);

   logic [NUM_CH-1:0] we, applied;
   logic [CNT_W-1:0]  lock_cnt, lock_nxt;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      // Out-of-range channel numbers match no channel and are dropped.
      assign we[k] = cfg_we && (cfg_ch == CH_W'(k));

      nco_chan #(
         .ACC_W    (ACC_W),
         .INIT_INC (INIT_INC[k*ACC_W +: ACC_W])
      ) u_chan (
         .clk_sys (clk_sys),
         .reset_n (reset_n),
         .en      (ch_en[k]),
         .we      (we[k]),
         .wdata   (cfg_data),
         .resync  (resync),
         .ce      (ce[k]),
         .pending (cfg_pending[k]),
         .applied (applied[k])
      );
   end

   always_comb begin
      lock_nxt = lock_cnt;
      if (resync || (|applied)) lock_nxt = CNT_W'(LOCK_CYCLES);
      else if (lock_cnt != '0) lock_nxt = lock_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         lock_cnt <= CNT_W'(LOCK_CYCLES);
         locked   <= 1'b0;
      end else begin
         lock_cnt <= lock_nxt;
         locked   <= (lock_nxt == '0);
      end
   end

endmodule
